// File: rtl/reg_file_sb.sv
// Integer register file with NUM_RD combinational read ports, one write port,
// hardwired-zero x0, write-to-read bypass and a per-register pending-write scoreboard.
// Optional debug read port and raw scoreboard view under `REGFILE_DBG_PORT_EN.
module reg_file_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NUM_RD = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS),
  localparam int CW     = $clog2(NREGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     w_en,
  input  logic [AW-1:0]            w_addr,
  input  logic [XLEN-1:0]          w_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
`ifdef REGFILE_DBG_PORT_EN
  input  logic [AW-1:0]            dbg_addr,
  output logic [XLEN-1:0]          dbg_data,
  output logic [NREGS-1:0]         dbg_busy_vec,
`endif
  output logic [CW-1:0]            busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [CW-1:0]    cnt_d;
  logic             w_hit;
  logic             iss_hit;

  // Writes and issues to x0 are architecturally void.
  assign w_hit   = w_en   && (w_addr   != '0);
  assign iss_hit = iss_en && (iss_addr != '0);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    if (w_hit)   busy_d[w_addr]   = 1'b0;
    // Applied after the clear so a same-address issue keeps the register busy.
    if (iss_hit) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  // NOTE: the storage array is reset because every register must read 0 straight out of reset;
  // this costs a reset net on each flop instead of allowing an SRAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (w_hit) begin
      regs[w_addr] <= w_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      busy_cnt <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = rd_addr[g*AW +: AW];

    always_comb begin
      data = regs[addr];
      bsy  = busy_q[addr];
      // A forwarded write retires the pending mark, unless a new writer is issued alongside it.
      if ((BYPASS != 0) && w_hit && (w_addr == addr)) begin
        data = w_data;
        if (!(iss_hit && (iss_addr == addr))) bsy = 1'b0;
      end
      // Keeps a bypassed write from leaking out while reset is held.
      if (!rst_n) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rd_data[g*XLEN +: XLEN] = data;
    assign rd_busy[g]              = bsy;
  end

`ifdef REGFILE_DBG_PORT_EN
  assign dbg_data     = rst_n ? regs[dbg_addr] : '0;
  assign dbg_busy_vec = busy_q;
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized self-checking bench for reg_file_sb: a bypassing and a non-bypassing
// instance share stimulus and are compared every cycle against an array-based model.
module tb_reg_file_sb;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 3;
  localparam int AW     = 5;
  localparam int CW     = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NUM_RD-1:0]      rd_busy_b, rd_busy_n;
  logic                   w_en, iss_en;
  logic [AW-1:0]          w_addr, iss_addr;
  logic [XLEN-1:0]        w_data;
  logic [CW-1:0]          cnt_b, cnt_n;
`ifdef REGFILE_DBG_PORT_EN
  logic [AW-1:0]          dbg_addr;
  logic [XLEN-1:0]        dbg_data_b, dbg_data_n;
  logic [NREGS-1:0]       dbg_vec_b, dbg_vec_n;
`endif

  int  vectors = 0;
  int  errors  = 0;
  bit  chk_en  = 1'b0;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .iss_en(iss_en), .iss_addr(iss_addr),
`ifdef REGFILE_DBG_PORT_EN
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .dbg_busy_vec(dbg_vec_b),
`endif
    .busy_cnt(cnt_b));

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .iss_en(iss_en), .iss_addr(iss_addr),
`ifdef REGFILE_DBG_PORT_EN
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_n), .dbg_busy_vec(dbg_vec_n),
`endif
    .busy_cnt(cnt_n));

  // Architectural model: register values and outstanding-writer flags.
  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        m_reg[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (w_en && w_addr != 0) begin
        m_reg[w_addr]  <= w_data;
        m_busy[w_addr] <= 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] <= 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(int p, bit byp);
    logic [AW-1:0] a = rd_addr[p*AW +: AW];
    if (!rst_n || a == 0) return '0;
    if (byp && w_en && w_addr == a) return w_data;
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(int p, bit byp);
    logic [AW-1:0] a = rd_addr[p*AW +: AW];
    if (!rst_n || a == 0) return 1'b0;
    if (byp && w_en && w_addr == a && !(iss_en && iss_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NUM_RD; p++) begin
        check($sformatf("rd_data_byp[%0d]", p), rd_data_b[p*XLEN +: XLEN], exp_data(p, 1'b1));
        check($sformatf("rd_data_nobyp[%0d]", p), rd_data_n[p*XLEN +: XLEN], exp_data(p, 1'b0));
        check($sformatf("rd_busy_byp[%0d]", p), XLEN'(rd_busy_b[p]), XLEN'(exp_busy(p, 1'b1)));
        check($sformatf("rd_busy_nobyp[%0d]", p), XLEN'(rd_busy_n[p]), XLEN'(exp_busy(p, 1'b0)));
      end
      check("busy_cnt_byp", XLEN'(cnt_b), XLEN'(exp_cnt()));
      check("busy_cnt_nobyp", XLEN'(cnt_n), XLEN'(exp_cnt()));
`ifdef REGFILE_DBG_PORT_EN
      check("dbg_data", dbg_data_b, rst_n ? m_reg[dbg_addr] : '0);
`endif
    end
  end

  task automatic set_in(bit we, int wa, logic [XLEN-1:0] wd, bit ie, int ia, int r0, int r1, int r2);
    w_en     = we;
    w_addr   = AW'(wa);
    w_data   = wd;
    iss_en   = ie;
    iss_addr = AW'(ia);
    rd_addr  = {AW'(r2), AW'(r1), AW'(r0)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(0, 0, '0, 0, 0, 0, 0, 0);
`ifdef REGFILE_DBG_PORT_EN
    dbg_addr = '0;
`endif
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    check("reset busy_cnt", XLEN'(cnt_b), 0);
    rst_n = 1'b1;

    // Write x5 then reset mid-cycle: contents vanish immediately.
    set_in(1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0);
    tick();
    set_in(0, 0, '0, 0, 0, 5, 0, 0);
    #1 check("x5 written", rd_data_b[31:0], 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1 check("x5 in reset", rd_data_b[31:0], 0);
    check("cnt in reset", XLEN'(cnt_b), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("x5 after reset", rd_data_n[31:0], 0);

    // x0 protection.
    set_in(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    #1 check("x0 read byp", rd_data_b[31:0], 0);
    check("x0 busy", XLEN'(rd_busy_b[0]), 0);
    tick();
    check("x0 cnt", XLEN'(cnt_b), 0);
    check("x0 after write", rd_data_n[31:0], 0);

    // Bypass on a busy x7: forwarded data and masked busy on the bypassing instance only.
    set_in(1, 7, 32'h11111111, 1, 7, 0, 0, 0);
    tick();
    set_in(1, 7, 32'h12345678, 0, 0, 7, 0, 0);
    #1 check("bypass data", rd_data_b[31:0], 32'h12345678);
    check("bypass busy", XLEN'(rd_busy_b[0]), 0);
    check("nobyp old data", rd_data_n[31:0], 32'h11111111);
    check("nobyp busy", XLEN'(rd_busy_n[0]), 1);
    tick();
    set_in(0, 0, '0, 0, 0, 7, 0, 0);
    #1 check("nobyp new data", rd_data_n[31:0], 32'h12345678);

    // Scoreboard: issue x3 at cycle 0, writeback at cycle 4.
    set_in(0, 0, '0, 1, 3, 3, 0, 0);
    tick();
    set_in(0, 0, '0, 0, 0, 3, 0, 0);
    #1 check("x3 busy c1", XLEN'(rd_busy_b[0]), 1);
    check("cnt c1", XLEN'(cnt_b), 1);
    tick(); tick(); tick();
    set_in(1, 3, 32'h33, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, '0, 0, 0, 3, 0, 0);
    #1 check("x3 busy c5", XLEN'(rd_busy_n[0]), 0);
    check("cnt c5", XLEN'(cnt_b), 0);

    // Set+clear on busy x9 in one cycle: busy survives, data forwarded.
    set_in(0, 0, '0, 1, 9, 0, 0, 0);
    tick();
    set_in(1, 9, 32'h99, 1, 9, 9, 0, 0);
    #1 check("x9 fwd data", rd_data_b[31:0], 32'h99);
    check("x9 busy unmasked", XLEN'(rd_busy_b[0]), 1);
    tick();
    set_in(0, 0, '0, 1, 11, 9, 0, 0);
    #1 check("x9 still busy", XLEN'(rd_busy_n[0]), 1);
    tick();
    check("cnt x9+x11", XLEN'(cnt_b), 2);
    set_in(1, 11, 32'hB, 1, 10, 0, 0, 0);
    tick();
    check("cnt net zero", XLEN'(cnt_b), 2);

    // Multi-port read of the same and different registers.
    set_in(1, 1, 32'd1, 0, 0, 0, 0, 0); tick();
    set_in(1, 2, 32'd2, 0, 0, 0, 0, 0); tick();
    set_in(1, 31, 32'd31, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, '0, 0, 0, 31, 2, 2);
    #1 check("port0 x31", rd_data_b[31:0], 32'd31);
    check("port1 x2", rd_data_b[63:32], 32'd2);
    check("port2 x2", rd_data_b[95:64], 32'd2);
    check("ports busy", XLEN'(rd_busy_b), 0);
    tick();

    // Randomized traffic with small-address bias and occasional mid-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      int r0, r1, r2, wa, ia;
      wa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NREGS - 1));
      ia = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, NREGS - 1));
      r0 = ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, NREGS - 1));
      r1 = ($urandom_range(0, 3) == 0) ? r0 : int'($urandom_range(0, NREGS - 1));
      r2 = ($urandom_range(0, 3) == 0) ? ia : int'($urandom_range(0, NREGS - 1));
      set_in(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ia, r0, r1, r2);
`ifdef REGFILE_DBG_PORT_EN
      dbg_addr = AW'($urandom_range(0, NREGS - 1));
`endif
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
